// File: rtl/load_scheduler_pkg.sv
// Shared types and constants for the LOAD-phase scheduler.
package lsch_pkg;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lsch_state_e;

    // Stream tags carried through the in-flight tag FIFO
    localparam logic TAG_IFM = 1'b0;
    localparam logic TAG_WGT = 1'b1;

    // Word-aligned byte address of word idx of a stream. Adding a multiple of 4
    // never carries out of bits [1:0], so masking afterwards equals masking the base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return (base + (idx << 2)) & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/load_scheduler_if.sv
// Shared memory read port: request/grant on the way out, in-order data on the way back.
interface load_scheduler_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_scheduler_tag_fifo.sv
// 1-bit synchronous FIFO remembering which stream each in-flight read belongs to.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   din,
    input  logic                   pop,
    output logic                   dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Tag storage, data only
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr] <= din;
    end

endmodule

// File: rtl/load_scheduler.sv
// LOAD-phase sequencer: round-robin IFM/weight fetch over one memory read port,
// in-order responses steered to the IFM or weight buffer write port.
module load_scheduler
    import lsch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          ifm_base,
    input  logic [31:0]          wgt_base,
    input  logic [CNT_W-1:0]     ifm_words,
    input  logic [CNT_W-1:0]     wgt_words,
    load_scheduler_if.master     mem,
    output logic                 ifm_wr_en,
    output logic [CNT_W-1:0]     ifm_wr_addr,
    output logic [31:0]          ifm_wr_data,
    output logic                 wgt_wr_en,
    output logic [CNT_W-1:0]     wgt_wr_addr,
    output logic [31:0]          wgt_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int FCW = $clog2(MAX_OUTSTANDING) + 1;

    lsch_state_e      state, state_nxt;
    logic             last_grant;
    logic [31:0]      ifm_base_q, wgt_base_q;
    logic [CNT_W-1:0] ifm_cnt, wgt_cnt;
    logic [CNT_W-1:0] ifm_iss, wgt_iss;
    logic [CNT_W-1:0] ifm_ret, wgt_ret;

    logic             ifm_elig, wgt_elig, sel, req;
    logic             issue, rsp_ok, room;
    logic             fifo_dout, fifo_full, fifo_empty;
    logic [FCW-1:0]   fifo_count;

    tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .din   (sel),
        .pop   (rsp_ok),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign room   = (fifo_count < FCW'(MAX_OUTSTANDING));
    assign issue  = req && mem.mem_gnt && !fifo_full;
    assign rsp_ok = mem.mem_rvalid && !fifo_empty && (state == LOAD || state == DRAIN);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // Next state, arbitration and request decode from registered state only
    always_comb begin
        state_nxt    = state;
        ifm_elig     = 1'b0;
        wgt_elig     = 1'b0;
        sel          = TAG_IFM;
        req          = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                ifm_elig = (ifm_iss < ifm_cnt) && room;
                wgt_elig = (wgt_iss < wgt_cnt) && room;
                if (ifm_elig && wgt_elig) sel = ~last_grant;
                else if (wgt_elig)        sel = TAG_WGT;
                req         = ifm_elig || wgt_elig;
                mem.mem_req = req;
                if (req) mem.mem_addr = (sel == TAG_IFM) ? word_addr(ifm_base_q, 32'(ifm_iss))
                                                         : word_addr(wgt_base_q, 32'(wgt_iss));
                if (ifm_iss == ifm_cnt && wgt_iss == wgt_cnt) state_nxt = DRAIN;
            end
            DRAIN: if (fifo_empty && ifm_ret == ifm_cnt && wgt_ret == wgt_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, issue/return counters, round-robin pointer, sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= TAG_WGT;
            ifm_iss    <= '0;
            wgt_iss    <= '0;
            ifm_ret    <= '0;
            wgt_ret    <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                ifm_iss <= '0;
                wgt_iss <= '0;
                ifm_ret <= '0;
                wgt_ret <= '0;
            end else begin
                if (issue) begin
                    if (sel == TAG_IFM) ifm_iss <= ifm_iss + 1'b1;
                    else                wgt_iss <= wgt_iss + 1'b1;
                    last_grant <= sel;
                end
                if (rsp_ok) begin
                    if (fifo_dout == TAG_IFM) ifm_ret <= ifm_ret + 1'b1;
                    else                      wgt_ret <= wgt_ret + 1'b1;
                end
            end
            if (mem.mem_rvalid && !rsp_ok) err <= 1'b1;
        end
    end

    // Load parameters captured once per start; ignored while a load is running
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            ifm_base_q <= ifm_base;
            wgt_base_q <= wgt_base;
            ifm_cnt    <= ifm_words;
            wgt_cnt    <= wgt_words;
        end
    end

    // Registered buffer write ports, one pulse per returned word
    always_ff @(posedge clk) begin
        if (rst) begin
            ifm_wr_en   <= 1'b0;
            ifm_wr_addr <= '0;
            ifm_wr_data <= '0;
            wgt_wr_en   <= 1'b0;
            wgt_wr_addr <= '0;
            wgt_wr_data <= '0;
        end else begin
            ifm_wr_en <= rsp_ok && (fifo_dout == TAG_IFM);
            wgt_wr_en <= rsp_ok && (fifo_dout == TAG_WGT);
            if (rsp_ok && fifo_dout == TAG_IFM) begin
                ifm_wr_addr <= ifm_ret;
                ifm_wr_data <= mem.mem_rdata;
            end
            if (rsp_ok && fifo_dout == TAG_WGT) begin
                wgt_wr_addr <= wgt_ret;
                wgt_wr_data <= mem.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_scheduler.sv
// Randomized self-checking bench for load_scheduler with a latency-queue memory model.
module tb_load_scheduler;
    import lsch_pkg::*;

    localparam int MAXO = 4;
    localparam int CW   = 20;

    typedef struct { logic tag; logic [31:0] addr; } req_t;
    typedef struct { int due; logic [31:0] addr; } pend_t;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [31:0]   ifm_base, wgt_base;
    logic [CW-1:0] ifm_words, wgt_words;
    logic          ifm_wr_en, wgt_wr_en;
    logic [CW-1:0] ifm_wr_addr, wgt_wr_addr;
    logic [31:0]   ifm_wr_data, wgt_wr_data;
    logic          busy, done, err;

    int    checks   = 0;
    int    failures = 0;
    logic  model_last;
    req_t  exp_q[$];
    pend_t pend[$];

    always #5 clk = ~clk;

    load_scheduler_if mem();

    load_scheduler #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ifm_base    (ifm_base),
        .wgt_base    (wgt_base),
        .ifm_words   (ifm_words),
        .wgt_words   (wgt_words),
        .mem         (mem),
        .ifm_wr_en   (ifm_wr_en),
        .ifm_wr_addr (ifm_wr_addr),
        .ifm_wr_data (ifm_wr_data),
        .wgt_wr_en   (wgt_wr_en),
        .wgt_wr_addr (wgt_wr_addr),
        .wgt_wr_data (wgt_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        model_last = TAG_WGT;
        pend.delete();
    endtask

    // One load: expected request order follows the round-robin rule on word counts alone,
    // since the in-flight limit throttles both streams alike.
    task automatic run_load(input logic [31:0] ib, input logic [31:0] wb, input int ni,
                            input int nw, input int lat, input int gnt_pct, input int abort_at);
        int    ii, iw, grants, iwc, wwc, done_cnt, done_t, last_wr_t;
        logic  lg, stall_prev, g, aborted;
        logic [31:0] addr_prev;
        req_t  r;
        pend_t p;
        exp_q.delete();
        ii = 0; iw = 0; lg = model_last;
        while (ii < ni || iw < nw) begin
            if (ii < ni && iw < nw) r.tag = ~lg;
            else                    r.tag = (ii < ni) ? TAG_IFM : TAG_WGT;
            if (r.tag == TAG_IFM) begin r.addr = (ib & ~32'h3) + 32'(ii) * 4; ii++; end
            else                  begin r.addr = (wb & ~32'h3) + 32'(iw) * 4; iw++; end
            exp_q.push_back(r);
            lg = r.tag;
        end

        @(negedge clk);
        start = 1'b1; ifm_base = ib; wgt_base = wb; ifm_words = CW'(ni); wgt_words = CW'(nw);
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
        grants = 0; iwc = 0; wwc = 0; done_cnt = 0; done_t = -1; last_wr_t = -1;
        stall_prev = 1'b0; addr_prev = '0; aborted = 1'b0;

        for (int t = 1; t <= 40 * (ni + nw) + 100; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_at >= 0 && grants == abort_at) begin
                rst = 1'b1; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
                aborted = 1'b1;
                break;
            end
            // scramble parameters and poke start while busy: latched values must hold
            ifm_base = $urandom; wgt_base = $urandom;
            ifm_words = CW'($urandom); wgt_words = CW'($urandom);
            if (busy && done_t < 0 && $urandom_range(0, 7) == 0) start = 1'b1;

            if (t == 1) begin
                chk("busy_rise", busy, 1);
                chk("req_rise", mem.mem_req, (ni + nw) > 0);
            end
            if (stall_prev) begin
                chk("stall_req", mem.mem_req, 1);
                chk("stall_addr", mem.mem_addr, addr_prev);
            end
            if (gnt_pct == 100 && lat < MAXO && grants < ni + nw)
                chk("full_rate", mem.mem_req, 1);

            g = ($urandom_range(0, 99) < gnt_pct);
            mem.mem_gnt = g;
            if (mem.mem_req && g) begin
                grants++;
                if (exp_q.size() == 0) chk("extra_req", grants, ni + nw);
                else begin
                    r = exp_q.pop_front();
                    chk("req_addr", mem.mem_addr, r.addr);
                end
                p.due = t + lat; p.addr = mem.mem_addr;
                pend.push_back(p);
                chk("inflight_max", pend.size() <= MAXO, 1);
            end
            stall_prev = mem.mem_req && !g;
            addr_prev  = mem.mem_addr;

            if (pend.size() > 0 && pend[0].due <= t) begin
                mem.mem_rvalid = 1'b1;
                mem.mem_rdata  = memval(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                mem.mem_rvalid = 1'b0;
                mem.mem_rdata  = $urandom;
            end

            if (ifm_wr_en) begin
                chk("ifm_wr_addr", ifm_wr_addr, CW'(iwc));
                chk("ifm_wr_data", ifm_wr_data, memval((ib & ~32'h3) + 32'(iwc) * 4));
                iwc++; last_wr_t = t;
            end
            if (wgt_wr_en) begin
                chk("wgt_wr_addr", wgt_wr_addr, CW'(wwc));
                chk("wgt_wr_data", wgt_wr_data, memval((wb & ~32'h3) + 32'(wwc) * 4));
                wwc++; last_wr_t = t;
            end
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        start = 1'b0;
        if (aborted) return;

        chk("done_seen", done_t >= 0, 1);
        chk("done_count", done_cnt, 1);
        chk("grants_total", grants, ni + nw);
        chk("ifm_writes", iwc, ni);
        chk("wgt_writes", wwc, nw);
        if (ni + nw == 0) chk("done_latency_zero", done_t, 3);
        else              chk("done_after_last_wr", done_t, last_wr_t + 1);
        chk("busy_end", busy, 0);
        chk("err_clean", err, 0);
        model_last = lg;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        ifm_base = '0; wgt_base = '0; ifm_words = '0; wgt_words = '0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        model_last = TAG_WGT;
        repeat (2) @(negedge clk);
        chk("rst_req", mem.mem_req, 0);
        chk("rst_addr", mem.mem_addr, 0);
        chk("rst_ifm_wr", {ifm_wr_en, ifm_wr_addr, ifm_wr_data}, 0);
        chk("rst_wgt_wr", {wgt_wr_en, wgt_wr_addr, wgt_wr_data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        run_load(32'h0000_1000, 32'h0000_8000, 8, 8, 2, 100, -1);
        run_load(32'h0000_4000, 32'h0000_9000, 5, 0, 3, 100, -1);
        run_load(32'h0000_5000, 32'h0000_6000, 0, 0, 2, 100, -1);
        run_load(32'h0000_0100, 32'h0000_0203, 0, 6, 1, 100, -1);
        for (int k = 0; k < 4; k++)
            run_load($urandom, $urandom, $urandom_range(3, 20), $urandom_range(3, 20), 6, 60, -1);
        run_load(32'hFFFF_FFF2, 32'h7FFF_FFFD, 6, 9, 4, 70, -1);

        // rvalid while idle: sticky error, no buffer write
        @(negedge clk);
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem.mem_rvalid = 1'b0;
        chk("err_set_idle", err, 1);
        chk("idle_no_ifm_wr", ifm_wr_en, 0);
        chk("idle_no_wgt_wr", wgt_wr_en, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        // reset in the middle of LOAD with 3 reads outstanding
        do_reset();
        chk("err_cleared", err, 0);
        run_load(32'h0000_2000, 32'h0000_3000, 10, 10, 6, 100, 3);
        @(negedge clk);
        rst = 1'b0;
        model_last = TAG_WGT;
        chk("abort_busy", busy, 0);
        chk("abort_req", mem.mem_req, 0);
        chk("abort_done", done, 0);
        while (pend.size() > 0) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = memval(pend[0].addr);
            void'(pend.pop_front());
            @(negedge clk);
            chk("stale_no_wr", ifm_wr_en | wgt_wr_en, 0);
        end
        mem.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stale_err", err, 1);
        do_reset();
        run_load(32'h0000_2000, 32'h0000_3000, 7, 4, 2, 100, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
